// File: rtl/acc_adapter_rsp.sv
// acc_adapter_rsp: buffers C-bus writeback responses and replays them to the
// core on the X-bus response channel, one register write per beat.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   acc_c_p_*            C-bus response channel in (valid/ready, data0/data1,
//                        rd, dualwb, error)
//   acc_x_p_*            X-bus writeback channel out (valid/ready, data, rd,
//                        error)
//   busy_o               response buffer holds at least one entry
//
// Dual-writeback responses leave as two beats: data0 to rd, then data1 to rd|1.
// A dual response with an odd rd cannot be split, so it goes out as a single
// data0 beat with the error flag forced.
module acc_adapter_rsp #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned RdWidth   = 5,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 acc_c_p_valid_i,
    output logic                 acc_c_p_ready_o,
    input  logic [DataWidth-1:0] acc_c_p_data0_i,
    input  logic [DataWidth-1:0] acc_c_p_data1_i,
    input  logic [RdWidth-1:0]   acc_c_p_rd_i,
    input  logic                 acc_c_p_dualwb_i,
    input  logic                 acc_c_p_error_i,
    output logic                 acc_x_p_valid_o,
    input  logic                 acc_x_p_ready_i,
    output logic [DataWidth-1:0] acc_x_p_data_o,
    output logic [RdWidth-1:0]   acc_x_p_rd_o,
    output logic                 acc_x_p_error_o,
    output logic                 busy_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    localparam logic [0:0] BEAT0 = 1'b0;
    localparam logic [0:0] BEAT1 = 1'b1;

    logic [DataWidth-1:0] d0_q   [FifoDepth];
    logic [DataWidth-1:0] d1_q   [FifoDepth];
    logic [RdWidth-1:0]   rd_q   [FifoDepth];
    logic                 dual_q [FifoDepth];
    logic                 err_q  [FifoDepth];

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [0:0]      state_q;

    logic [DataWidth-1:0] h_d0;
    logic [DataWidth-1:0] h_d1;
    logic [RdWidth-1:0]   h_rd;
    logic                 h_dual;
    logic                 h_err;
    logic                 h_split;
    logic                 h_bad;
    logic                 push;
    logic                 pop;
    logic                 x_hs;

    assign h_d0   = d0_q[rd_ptr_q];
    assign h_d1   = d1_q[rd_ptr_q];
    assign h_rd   = rd_q[rd_ptr_q];
    assign h_dual = dual_q[rd_ptr_q];
    assign h_err  = err_q[rd_ptr_q];

    // Only an even rd can pair with rd|1; an odd one is reported as an error.
    assign h_split = h_dual & ~h_rd[0];
    assign h_bad   = h_dual & h_rd[0];

    assign acc_c_p_ready_o = (count_q < CntW'(FifoDepth));
    assign acc_x_p_valid_o = (count_q != '0);
    assign busy_o          = (count_q != '0);

    assign push = acc_c_p_valid_i & acc_c_p_ready_o;
    assign x_hs = acc_x_p_valid_o & acc_x_p_ready_i;
    // The head only retires on its last beat.
    assign pop  = x_hs & ((state_q == BEAT1) | ~h_split);

    always_comb begin
        acc_x_p_data_o  = h_d0;
        acc_x_p_rd_o    = h_rd;
        acc_x_p_error_o = h_err | h_bad;
        if (state_q == BEAT1) begin
            acc_x_p_data_o  = h_d1;
            acc_x_p_rd_o    = h_rd | RdWidth'(1);
            acc_x_p_error_o = h_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                d0_q[i]   <= '0;
                d1_q[i]   <= '0;
                rd_q[i]   <= '0;
                dual_q[i] <= 1'b0;
                err_q[i]  <= 1'b0;
            end
        end else if (push) begin
            d0_q[wr_ptr_q]   <= acc_c_p_data0_i;
            d1_q[wr_ptr_q]   <= acc_c_p_data1_i;
            rd_q[wr_ptr_q]   <= acc_c_p_rd_i;
            dual_q[wr_ptr_q] <= acc_c_p_dualwb_i;
            err_q[wr_ptr_q]  <= acc_c_p_error_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= BEAT0;
        end else begin
            if (push) begin
                if (wr_ptr_q == PtrW'(FifoDepth - 1)) wr_ptr_q <= '0;
                else wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                if (rd_ptr_q == PtrW'(FifoDepth - 1)) rd_ptr_q <= '0;
                else rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
            if (x_hs) begin
                if ((state_q == BEAT0) && h_split) state_q <= BEAT1;
                else state_q <= BEAT0;
            end
        end
    end

endmodule

// File: tb/tb_acc_adapter_rsp.sv
// Directed bench for acc_adapter_rsp: a per-cycle vector table plus a
// hand-written reset-during-BEAT1 sequence.
module tb_acc_adapter_rsp;

    logic        clk_i;
    logic        rst_ni;
    logic        c_valid;
    logic        c_ready;
    logic [31:0] c_d0;
    logic [31:0] c_d1;
    logic [4:0]  c_rd;
    logic        c_dual;
    logic        c_err;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_data;
    logic [4:0]  x_rd;
    logic        x_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    acc_adapter_rsp #(
        .DataWidth(32),
        .RdWidth  (5),
        .FifoDepth(2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .acc_c_p_valid_i (c_valid),
        .acc_c_p_ready_o (c_ready),
        .acc_c_p_data0_i (c_d0),
        .acc_c_p_data1_i (c_d1),
        .acc_c_p_rd_i    (c_rd),
        .acc_c_p_dualwb_i(c_dual),
        .acc_c_p_error_i (c_err),
        .acc_x_p_valid_o (x_valid),
        .acc_x_p_ready_i (x_ready),
        .acc_x_p_data_o  (x_data),
        .acc_x_p_rd_o    (x_rd),
        .acc_x_p_error_o (x_err),
        .busy_o          (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [4:0]  rd;
        logic        dw;
        logic        er;
        logic        rdy;
        logic        e_cr;
        logic        e_val;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic v, input logic [31:0] d0, input logic [31:0] d1,
        input logic [4:0] rd, input logic dw, input logic er, input logic rdy,
        input logic e_cr, input logic e_val, input logic [31:0] e_data,
        input logic [4:0] e_rd, input logic e_err, input logic e_busy);
        vec_t t;
        t.v = v; t.d0 = d0; t.d1 = d1; t.rd = rd; t.dw = dw; t.er = er;
        t.rdy = rdy; t.e_cr = e_cr; t.e_val = e_val; t.e_data = e_data;
        t.e_rd = e_rd; t.e_err = e_err; t.e_busy = e_busy;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        c_valid = 1'b0; c_d0 = '0; c_d1 = '0; c_rd = '0;
        c_dual = 1'b0; c_err = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        x_ready = 1'b0;
        idle_inputs();

        //   v  d0            d1            rd dw er rdy  cr val data          rd err busy
        // single beat
        add(1, 32'hDEADBEEF, 32'h0,        5, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'hDEADBEEF, 5, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        // dual writeback: rd then rd|1, back-to-back
        add(1, 32'h11111111, 32'h22222222, 10, 1, 0, 1, 1, 0, 32'h0,        0, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h11111111, 10, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h22222222, 11, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        // dual with odd rd: one beat, error forced
        add(1, 32'hAAAA0007, 32'hBBBB0007, 7, 1, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'hAAAA0007, 7, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        // backpressure: third push refused, order kept
        add(1, 32'h100,      32'h0,        1, 0, 0, 0,  1, 0, 32'h0,        0, 0, 0);
        add(1, 32'h200,      32'h0,        2, 0, 0, 0,  1, 1, 32'h100,      1, 0, 1);
        add(1, 32'h300,      32'h0,        3, 0, 0, 0,  0, 1, 32'h100,      1, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,  0, 1, 32'h100,      1, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  0, 1, 32'h100,      1, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h200,      2, 0, 1);
        add(1, 32'h300,      32'h0,        3, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h300,      3, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        // full with simultaneous pop: push refused, taken next cycle
        add(1, 32'h400,      32'h0,        4, 0, 0, 0,  1, 0, 32'h0,        0, 0, 0);
        add(1, 32'h600,      32'h0,        6, 0, 0, 0,  1, 1, 32'h400,      4, 0, 1);
        add(1, 32'h800,      32'h0,        8, 0, 0, 1,  0, 1, 32'h400,      4, 0, 1);
        add(1, 32'h800,      32'h0,        8, 0, 0, 0,  1, 1, 32'h600,      6, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  0, 1, 32'h600,      6, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h800,      8, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        // rd=0 and accelerator error passed through
        add(1, 32'h0000CAFE, 32'h0,        0, 0, 1, 1,  1, 0, 32'h0,        0, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h0000CAFE, 0, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        // dual stalled in BEAT1 while another response is pushed
        add(1, 32'h21,       32'h22,       2, 1, 0, 1,  1, 0, 32'h0,        0, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,  1, 1, 32'h21,       2, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h21,       2, 0, 1);
        add(1, 32'h55,       32'h0,        9, 0, 0, 0,  1, 1, 32'h22,       3, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  0, 1, 32'h22,       3, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 1, 32'h55,       9, 0, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);

        // reset state
        repeat (2) @(negedge clk_i);
        chk("reset_ctrl", {61'd0, c_ready, x_valid, busy}, {61'd0, 3'b100});
        chk("reset_out", {26'd0, x_data, x_rd, x_err}, 64'd0);
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk_i);
            c_valid = tbl[i].v;   c_d0 = tbl[i].d0; c_d1 = tbl[i].d1;
            c_rd    = tbl[i].rd;  c_dual = tbl[i].dw; c_err = tbl[i].er;
            x_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_ctrl", i), {61'd0, c_ready, x_valid, busy},
                {61'd0, tbl[i].e_cr, tbl[i].e_val, tbl[i].e_busy});
            if (tbl[i].e_val)
                chk($sformatf("row%0d_beat", i), {26'd0, x_data, x_rd, x_err},
                    {26'd0, tbl[i].e_data, tbl[i].e_rd, tbl[i].e_err});
        end

        // reset during BEAT1 of a dual response
        @(negedge clk_i);
        idle_inputs();
        c_valid = 1'b1; c_d0 = 32'hA1; c_d1 = 32'hA2; c_rd = 5'd12; c_dual = 1'b1;
        x_ready = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("rst_seq_beat0", {26'd0, x_valid, x_data, x_rd},
            {26'd0, 1'b1, 32'hA1, 5'd12});
        @(negedge clk_i);
        x_ready = 1'b0;
        #1;
        chk("rst_seq_beat1", {26'd0, x_valid, x_data, x_rd},
            {26'd0, 1'b1, 32'hA2, 5'd13});
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_async", {61'd0, x_valid, busy, c_ready}, {61'd0, 3'b001});
        chk("rst_async_out", {26'd0, x_data, x_rd, x_err}, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni  = 1'b1;
        x_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            #1;
            chk($sformatf("post_rst%0d", k), {62'd0, x_valid, busy}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
